// File: rtl/encoder_rr_arbiter.sv
// Registered N-input request encoder with fixed or round-robin priority behind a valid/ready output.
// Optional accepted-grant counter on grant_count_out when ENCODER_STATS_EN is defined.
module encoder_rr_arbiter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk_in,
    input  logic         reset_in,
    input  logic [N-1:0] req_in,
    input  logic         mode_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] y_out,
    output logic [N-1:0] onehot_out,
    output logic         invalid_data,
    output logic         dbg_state_o,
    output logic [W-1:0] dbg_ptr_o
`ifdef ENCODER_STATS_EN
    ,
    output logic [15:0]  grant_count_out
`endif
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   y_q, y_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   oh_q, oh_d;
    logic           inv_q;

    logic           accept;
    logic           load;
    logic [W-1:0]   ptr_next;
    logic [W-1:0]   rr_start;
    logic [W-1:0]   fixed_win;
    logic [W-1:0]   rr_win;
    logic [W-1:0]   win;
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_rot2;
    logic [N-1:0]   req_rot;
    logic [W-1:0]   rr_off;
    logic [W:0]     rr_sum;

    // Handshake: a result is transferred on any cycle where out_valid and out_ready
    // are both high; while out_valid is high and out_ready low, the result is frozen.
    assign accept   = (state_q == S_FULL) && out_ready;
    assign load     = (|req_in) && ((state_q == S_EMPTY) || accept);
    assign ptr_next = (y_q == W'(N - 1)) ? '0 : y_q + 1'b1;
    // On an accept the search starts after the grant being retired, not from the stale pointer.
    assign rr_start = accept ? ptr_next : ptr_q;

    always_comb begin
        fixed_win = '0;
        for (int i = 0; i < N; i++) begin
            if (req_in[i]) fixed_win = W'(i);
        end
    end

    // Rotate so bit 0 is the start position, then take the lowest set offset.
    assign req_dbl  = {req_in, req_in};
    assign req_rot2 = req_dbl >> rr_start;
    assign req_rot  = req_rot2[N-1:0];

    always_comb begin
        rr_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) rr_off = W'(k);
        end
        rr_sum = {1'b0, rr_start} + {1'b0, rr_off};
        if (rr_sum >= (W+1)'(N)) rr_sum = rr_sum - (W+1)'(N);
        rr_win = rr_sum[W-1:0];
    end

    assign win = mode_in ? rr_win : fixed_win;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        oh_d    = oh_q;
        ptr_d   = ptr_q;
        if (accept) ptr_d = ptr_next;
        if (load) begin
            state_d = S_FULL;
            y_d     = win;
            oh_d    = {{(N-1){1'b0}}, 1'b1} << win;
        end else if ((state_q == S_EMPTY) || accept) begin
            state_d = S_EMPTY;
            oh_d    = '0;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= S_EMPTY;
            y_q     <= '0;
            oh_q    <= '0;
            ptr_q   <= '0;
            inv_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            oh_q    <= oh_d;
            ptr_q   <= ptr_d;
            inv_q   <= ~|req_in;
        end
    end

    assign out_valid    = (state_q == S_FULL);
    assign y_out        = y_q;
    assign onehot_out   = oh_q;
    assign invalid_data = inv_q;
    assign dbg_state_o  = (state_q == S_FULL);
    assign dbg_ptr_o    = ptr_q;

`ifdef ENCODER_STATS_EN
    logic [15:0] grant_cnt_q;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            grant_cnt_q <= '0;
        end else if (accept && (grant_cnt_q != 16'hFFFF)) begin
            grant_cnt_q <= grant_cnt_q + 16'd1;
        end
    end

    assign grant_count_out = grant_cnt_q;
`endif

endmodule

// File: tb/tb_encoder_rr_arbiter.sv
// Bench for encoder_rr_arbiter: directed scenarios plus random traffic on N=4 and N=5 instances
// checked against a behavioural model of the grant rules.
module tb_encoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req4;
    logic [4:0] req5;
    logic       mode;
    logic       ready;

    logic       v4, inv4, st4;
    logic [1:0] y4, ptr4;
    logic [3:0] oh4;
    logic       v5, inv5, st5;
    logic [2:0] y5, ptr5;
    logic [4:0] oh5;
`ifdef ENCODER_STATS_EN
    logic [15:0] gc4, gc5;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state, index 0 = N=4 instance, index 1 = N=5 instance.
    bit mv[2];
    int my[2];
    int mp[2];
    bit minv[2];
    int mcnt[2];

    always #5 clk = ~clk;

    encoder_rr_arbiter #(.N(4)) dut4 (
        .clk_in(clk), .reset_in(rst), .req_in(req4), .mode_in(mode), .out_ready(ready),
        .out_valid(v4), .y_out(y4), .onehot_out(oh4), .invalid_data(inv4),
        .dbg_state_o(st4), .dbg_ptr_o(ptr4)
`ifdef ENCODER_STATS_EN
        , .grant_count_out(gc4)
`endif
    );

    encoder_rr_arbiter #(.N(5)) dut5 (
        .clk_in(clk), .reset_in(rst), .req_in(req5), .mode_in(mode), .out_ready(ready),
        .out_valid(v5), .y_out(y5), .onehot_out(oh5), .invalid_data(inv5),
        .dbg_state_o(st5), .dbg_ptr_o(ptr5)
`ifdef ENCODER_STATS_EN
        , .grant_count_out(gc5)
`endif
    );

    function automatic int pick(int n, int r, bit md, int start);
        if (!md) begin
            for (int i = n - 1; i >= 0; i--)
                if (((r >> i) & 1) != 0) return i;
        end else begin
            for (int k = 0; k < n; k++) begin
                int j;
                j = (start + k) % n;
                if (((r >> j) & 1) != 0) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; my[i] = 0; mp[i] = 0; minv[i] = 1; mcnt[i] = 0;
        end
    endtask

    task automatic model_step(int inst, int n, int r, bit md, bit rd);
        bit acc;
        int old_y;
        acc   = mv[inst] && rd;
        old_y = my[inst];
        if (!mv[inst] || acc) begin
            if (r != 0) begin
                my[inst] = pick(n, r, md, acc ? (old_y + 1) % n : mp[inst]);
                mv[inst] = 1;
            end else begin
                mv[inst] = 0;
            end
        end
        if (acc) begin
            mp[inst] = (old_y + 1) % n;
            if (mcnt[inst] < 65535) mcnt[inst]++;
        end
        minv[inst] = (r == 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step(0, 4, int'(req4), mode, ready);
        model_step(1, 5, int'(req5), mode, ready);
    endtask

    task automatic do_reset();
        rst = 1'b1; req4 = '0; req5 = '0; mode = 1'b0; ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; req4 = 4'b1111; req5 = '0; mode = 1'b0; ready = 1'b1;
        @(posedge clk); #2;
        n_vec += 6;
        if (v4 !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", v4); end
        if (y4 !== 2'd0) begin n_err++; $display("FAIL reset y_out: got %0d want 0", y4); end
        if (oh4 !== 4'b0) begin n_err++; $display("FAIL reset onehot: got %b want 0000", oh4); end
        if (inv4 !== 1'b1) begin n_err++; $display("FAIL reset invalid_data: got %b want 1", inv4); end
        if (ptr4 !== 2'd0) begin n_err++; $display("FAIL reset ptr: got %0d want 0", ptr4); end
        if (st4 !== 1'b0) begin n_err++; $display("FAIL reset state: got %b want 0", st4); end
        do_reset();
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0; ready = 1'b1; req4 = 4'b0110;
        cycle();
        n_vec += 4;
        if (v4 !== 1'b1) begin n_err++; $display("FAIL fixed out_valid: got %b want 1", v4); end
        if (y4 !== 2'd2) begin n_err++; $display("FAIL fixed y_out: got %0d want 2", y4); end
        if (oh4 !== 4'b0100) begin n_err++; $display("FAIL fixed onehot: got %b want 0100", oh4); end
        if (inv4 !== 1'b0) begin n_err++; $display("FAIL fixed invalid_data: got %b want 0", inv4); end
        req4 = 4'b0000;
        cycle();
        n_vec += 3;
        if (v4 !== 1'b0) begin n_err++; $display("FAIL fixed drain valid: got %b want 0", v4); end
        if (oh4 !== 4'b0) begin n_err++; $display("FAIL fixed drain onehot: got %b want 0000", oh4); end
        if (inv4 !== 1'b1) begin n_err++; $display("FAIL fixed drain invalid: got %b want 1", inv4); end
    endtask

    task automatic test_rr_sequence();
        int exp_y[5] = '{0, 1, 2, 3, 0};
        do_reset();
        mode = 1'b1; ready = 1'b1; req4 = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_vec += 2;
            if (v4 !== 1'b1) begin n_err++; $display("FAIL rr_seq valid c%0d: got %b want 1", c, v4); end
            if (int'(y4) != exp_y[c]) begin n_err++; $display("FAIL rr_seq y c%0d: got %0d want %0d", c, y4, exp_y[c]); end
        end
    endtask

    task automatic test_rr_wrap5();
        int exp_y[4] = '{0, 4, 0, 4};
        int exp_p[4] = '{0, 1, 0, 1};
        do_reset();
        mode = 1'b1; ready = 1'b1; req5 = 5'b10001;
        for (int c = 0; c < 4; c++) begin
            cycle();
            n_vec += 2;
            if (int'(y5) != exp_y[c]) begin n_err++; $display("FAIL wrap5 y c%0d: got %0d want %0d", c, y5, exp_y[c]); end
            if (int'(ptr5) != exp_p[c]) begin n_err++; $display("FAIL wrap5 ptr c%0d: got %0d want %0d", c, ptr5, exp_p[c]); end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        mode = 1'b0; ready = 1'b1; req4 = 4'b1000;
        cycle();
        ready = 1'b0; req4 = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) mode = 1'b1;
            cycle();
            n_vec += 3;
            if (v4 !== 1'b1) begin n_err++; $display("FAIL bp valid c%0d: got %b want 1", c, v4); end
            if (y4 !== 2'd3) begin n_err++; $display("FAIL bp y c%0d: got %0d want 3", c, y4); end
            if (oh4 !== 4'b1000) begin n_err++; $display("FAIL bp onehot c%0d: got %b want 1000", c, oh4); end
        end
        ready = 1'b1;
        cycle();
        n_vec += 3;
        if (v4 !== 1'b1) begin n_err++; $display("FAIL bp release valid: got %b want 1", v4); end
        if (y4 !== 2'd0) begin n_err++; $display("FAIL bp release y: got %0d want 0", y4); end
        if (ptr4 !== 2'd0) begin n_err++; $display("FAIL bp release ptr: got %0d want 0", ptr4); end
    endtask

    task automatic test_idle_zero();
        do_reset();
        ready = 1'b1; req4 = '0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_vec += 2;
            if (v4 !== 1'b0) begin n_err++; $display("FAIL idle valid c%0d: got %b want 0", c, v4); end
            if (inv4 !== 1'b1) begin n_err++; $display("FAIL idle invalid c%0d: got %b want 1", c, inv4); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 1'b1; ready = 1'b1; req4 = 4'b1111;
        cycle();
        cycle();
        ready = 1'b0;
        n_vec += 2;
        if (ptr4 !== 2'd1) begin n_err++; $display("FAIL areset pre ptr: got %0d want 1", ptr4); end
        if (v4 !== 1'b1) begin n_err++; $display("FAIL areset pre valid: got %b want 1", v4); end
        #3 rst = 1'b1;
        #1;
        n_vec += 3;
        if (v4 !== 1'b0) begin n_err++; $display("FAIL areset valid: got %b want 0", v4); end
        if (oh4 !== 4'b0) begin n_err++; $display("FAIL areset onehot: got %b want 0000", oh4); end
        if (ptr4 !== 2'd0) begin n_err++; $display("FAIL areset ptr: got %0d want 0", ptr4); end
        #2 rst = 1'b0;
        model_reset();
        ready = 1'b1;
        cycle();
        n_vec += 2;
        if (v4 !== 1'b1) begin n_err++; $display("FAIL areset reload valid: got %b want 1", v4); end
        if (y4 !== 2'd0) begin n_err++; $display("FAIL areset reload y: got %0d want 0", y4); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req4  = ($urandom_range(0, 5) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
            req5  = ($urandom_range(0, 5) == 0) ? 5'b0 : 5'($urandom_range(0, 31));
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            cycle();
            n_vec += 6;
            if (v4 !== mv[0]) begin n_err++; $display("FAIL rnd4 valid c%0d: got %b want %b", c, v4, mv[0]); end
            if (mv[0] && int'(y4) != my[0]) begin n_err++; $display("FAIL rnd4 y c%0d: got %0d want %0d", c, y4, my[0]); end
            if (int'(oh4) != (mv[0] ? (1 << my[0]) : 0)) begin n_err++; $display("FAIL rnd4 onehot c%0d: got %b want y=%0d v=%b", c, oh4, my[0], mv[0]); end
            if (int'(ptr4) != mp[0]) begin n_err++; $display("FAIL rnd4 ptr c%0d: got %0d want %0d", c, ptr4, mp[0]); end
            if (inv4 !== minv[0]) begin n_err++; $display("FAIL rnd4 invalid c%0d: got %b want %b", c, inv4, minv[0]); end
            if (v5 !== mv[1]) begin n_err++; $display("FAIL rnd5 valid c%0d: got %b want %b", c, v5, mv[1]); end
            n_vec += 4;
            if (mv[1] && int'(y5) != my[1]) begin n_err++; $display("FAIL rnd5 y c%0d: got %0d want %0d", c, y5, my[1]); end
            if (int'(oh5) != (mv[1] ? (1 << my[1]) : 0)) begin n_err++; $display("FAIL rnd5 onehot c%0d: got %b want y=%0d v=%b", c, oh5, my[1], mv[1]); end
            if (int'(ptr5) != mp[1]) begin n_err++; $display("FAIL rnd5 ptr c%0d: got %0d want %0d", c, ptr5, mp[1]); end
            if (inv5 !== minv[1]) begin n_err++; $display("FAIL rnd5 invalid c%0d: got %b want %b", c, inv5, minv[1]); end
        end
    endtask

`ifdef ENCODER_STATS_EN
    task automatic test_stats();
        do_reset();
        mode = 1'b0; ready = 1'b1; req4 = 4'b0001;
        for (int c = 0; c < 11; c++) cycle();
        n_vec += 1;
        if (gc4 !== 16'd10) begin n_err++; $display("FAIL stats count: got %0d want 10", gc4); end
        dut4.grant_cnt_q = 16'hFFFE;
        for (int c = 0; c < 3; c++) cycle();
        n_vec += 1;
        if (gc4 !== 16'hFFFF) begin n_err++; $display("FAIL stats saturate: got %h want ffff", gc4); end
    endtask
`endif

    initial begin
        test_reset();
        test_fixed();
        test_rr_sequence();
        test_rr_wrap5();
        test_back_pressure();
        test_idle_zero();
        test_async_reset();
        test_random();
`ifdef ENCODER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
